// File: rtl/ranc_pkg.sv
// ---------------------------------------------------------------------------
// ranc_pkg
// Shared definitions for the RANC grid input path: grid packet width and
// field layout, error_flags bit positions and the tick-feeder state type.
// No ports (package only).
// ---------------------------------------------------------------------------
package ranc_pkg;

    // One grid input packet: {dx, dy, axon, tick_offset}
    localparam int PACKET_WIDTH    = 30;

    localparam int DX_WIDTH        = 9;
    localparam int DY_WIDTH        = 9;
    localparam int AXON_WIDTH      = 8;
    localparam int TICK_OFS_WIDTH  = 4;

    localparam int TICK_OFS_LSB    = 0;
    localparam int AXON_LSB        = TICK_OFS_LSB + TICK_OFS_WIDTH;
    localparam int DY_LSB          = AXON_LSB + AXON_WIDTH;
    localparam int DX_LSB          = DY_LSB + DY_WIDTH;

    // Sticky error flag bit positions
    localparam int ERR_WIDTH       = 3;
    localparam int ERR_OVERFLOW    = 0;
    localparam int ERR_UNDERRUN    = 1;
    localparam int ERR_SKIP        = 2;

    // Release side of the feeder: idle between ticks, or streaming a frame
    typedef enum logic {
        WAIT_TICK = 1'b0,
        STREAM    = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/ranc_sync_fifo.sv
// ---------------------------------------------------------------------------
// ranc_sync_fifo
// Single-clock FIFO with a show-ahead read port and a flush-by-N input that
// discards N entries from the head in one cycle.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (pointers only)
//   wr_en, wr_data        push (caller guarantees not full)
//   rd_en                 pop one entry (caller guarantees not empty)
//   flush_en, flush_cnt   drop flush_cnt entries from the head (ignored if rd_en)
//   rd_data               current head entry
//   count                 number of stored entries
// ---------------------------------------------------------------------------
module ranc_sync_fifo #(
    parameter int WIDTH       = 30,
    parameter int DEPTH       = 16,
    parameter int FLUSH_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     flush_en,
    input  logic [FLUSH_WIDTH-1:0]   flush_cnt,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rd_step;

    // Pointers wrap naturally because DEPTH is a power of two; a flush just
    // moves the read pointer further than a normal pop would.
    always_comb begin
        rd_step = '0;
        if (rd_en) begin
            rd_step = CNT_W'(1);
        end else if (flush_en) begin
            rd_step = CNT_W'(flush_cnt);
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + rd_step[PTR_W-1:0];
        count_d  = count_q + CNT_W'(wr_en) - rd_step;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array carries no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ranc_tick_packet_feeder.sv
// ---------------------------------------------------------------------------
// ranc_tick_packet_feeder
// Buffers host-written grid packets grouped into frames and releases exactly
// one frame to the RANC grid per tick.
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   wr_en, wr_packet, wr_frame_end     host write side
//   full                               host must not write while high
//   tick                               one-cycle tick pulse
//   ren_to_input_buffer                grid read request
//   packet_in                          registered packet to the grid
//   input_buffer_empty                 nothing left to read this tick
//   frames_pending                     closed frames not yet released
//   error_flags                        sticky {skip, underrun, overflow}
// ---------------------------------------------------------------------------
module ranc_tick_packet_feeder
    import ranc_pkg::*;
#(
    parameter int PACKET_WIDTH = ranc_pkg::PACKET_WIDTH,
    parameter int DEPTH        = 16384,
    parameter int FRAME_DEPTH  = 128,
    parameter int COUNT_WIDTH  = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [PACKET_WIDTH-1:0]        wr_packet,
    input  logic                           wr_frame_end,
    output logic                           full,
    input  logic                           tick,
    input  logic                           ren_to_input_buffer,
    output logic [PACKET_WIDTH-1:0]        packet_in,
    output logic                           input_buffer_empty,
    output logic [$clog2(FRAME_DEPTH):0]   frames_pending,
    output logic [ERR_WIDTH-1:0]           error_flags
);

    localparam int PKT_CNT_W = $clog2(DEPTH) + 1;
    localparam int FRM_CNT_W = $clog2(FRAME_DEPTH) + 1;

    feeder_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0]    acc_cnt_q, acc_cnt_d;
    logic [PACKET_WIDTH-1:0]   packet_in_q, packet_in_d;
    logic                      empty_q, empty_d;
    logic [ERR_WIDTH-1:0]      err_q, err_d;

    logic                      pkt_push, pkt_pop, pkt_flush;
    logic [PACKET_WIDTH-1:0]   pkt_head;
    logic [PKT_CNT_W-1:0]      pkt_count;
    logic                      frm_push, frm_pop;
    logic [COUNT_WIDTH-1:0]    frm_wdata, frm_head;
    logic [FRM_CNT_W-1:0]      frm_count;
    logic                      pkt_full, frm_full;
    logic                      load_frame;

    ranc_sync_fifo #(
        .WIDTH       (PACKET_WIDTH),
        .DEPTH       (DEPTH),
        .FLUSH_WIDTH (COUNT_WIDTH)
    ) u_packet_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (pkt_push),
        .wr_data   (wr_packet),
        .rd_en     (pkt_pop),
        .flush_en  (pkt_flush),
        .flush_cnt (remaining_q),
        .rd_data   (pkt_head),
        .count     (pkt_count)
    );

    ranc_sync_fifo #(
        .WIDTH       (COUNT_WIDTH),
        .DEPTH       (FRAME_DEPTH),
        .FLUSH_WIDTH (1)
    ) u_frame_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (frm_push),
        .wr_data   (frm_wdata),
        .rd_en     (frm_pop),
        .flush_en  (1'b0),
        .flush_cnt (1'b0),
        .rd_data   (frm_head),
        .count     (frm_count)
    );

    assign pkt_full = (pkt_count == PKT_CNT_W'(DEPTH));
    assign frm_full = (frm_count == FRM_CNT_W'(FRAME_DEPTH));
    assign full     = pkt_full || frm_full;

    // Write side: a closing frame includes a packet accepted in the same
    // cycle. A rejected frame close keeps the accumulator so the host can
    // retry once the frame queue drains.
    always_comb begin
        pkt_push  = wr_en && !full;
        frm_push  = wr_frame_end && !frm_full;
        frm_wdata = acc_cnt_q + COUNT_WIDTH'(pkt_push);
        acc_cnt_d = acc_cnt_q;
        if (frm_push) begin
            acc_cnt_d = '0;
        end else if (pkt_push) begin
            acc_cnt_d = acc_cnt_q + COUNT_WIDTH'(1);
        end
    end

    // Release FSM. A tick always wins over a read; when it lands mid-frame
    // the unread remainder is flushed so the next frame starts aligned.
    // Frames closed in this very cycle are not yet counted, so they are
    // never released early.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        packet_in_d = packet_in_q;
        err_d       = err_q;
        pkt_pop     = 1'b0;
        pkt_flush   = 1'b0;
        frm_pop     = 1'b0;
        load_frame  = 1'b0;

        if ((wr_en && full) || (wr_frame_end && frm_full)) begin
            err_d[ERR_OVERFLOW] = 1'b1;
        end

        case (state_q)
            WAIT_TICK: begin
                if (tick) begin
                    load_frame = 1'b1;
                end
            end
            STREAM: begin
                if (tick) begin
                    if (remaining_q != '0) begin
                        pkt_flush       = 1'b1;
                        err_d[ERR_SKIP] = 1'b1;
                    end
                    load_frame = 1'b1;
                end else if (ren_to_input_buffer && remaining_q != '0) begin
                    pkt_pop     = 1'b1;
                    packet_in_d = pkt_head;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_d == '0) begin
                        state_d = WAIT_TICK;
                    end
                end
            end
            default: state_d = WAIT_TICK;
        endcase

        if (load_frame) begin
            remaining_d = '0;
            state_d     = WAIT_TICK;
            if (frm_count != '0) begin
                frm_pop     = 1'b1;
                remaining_d = frm_head;
                if (frm_head != '0) begin
                    state_d = STREAM;
                end
            end else begin
                err_d[ERR_UNDERRUN] = 1'b1;
            end
        end

        empty_d = (remaining_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= WAIT_TICK;
            remaining_q <= '0;
            acc_cnt_q   <= '0;
            packet_in_q <= '0;
            empty_q     <= 1'b1;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_cnt_q   <= acc_cnt_d;
            packet_in_q <= packet_in_d;
            empty_q     <= empty_d;
            err_q       <= err_d;
        end
    end

    assign packet_in          = packet_in_q;
    assign input_buffer_empty = empty_q;
    assign frames_pending     = frm_count;
    assign error_flags        = err_q;

endmodule

// File: tb/tb_ranc_tick_packet_feeder.sv
// ---------------------------------------------------------------------------
// tb_ranc_tick_packet_feeder
// Self-checking bench: directed scenarios with constant expectations plus a
// randomized run compared against a queue-based model of frames and packets.
// ---------------------------------------------------------------------------
module tb_ranc_tick_packet_feeder;

    localparam int PW     = 30;
    localparam int DEPTH  = 16384;
    localparam int FDEPTH = 128;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [PW-1:0] wr_packet;
    logic          wr_frame_end;
    logic          full;
    logic          tick;
    logic          ren;
    logic [PW-1:0] packet_in;
    logic          input_buffer_empty;
    logic [7:0]    frames_pending;
    logic [2:0]    error_flags;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: every stored packet in arrival order, the lengths of
    // closed frames, the open-frame size and the unread part of the frame
    // currently released to the grid.
    logic [PW-1:0] m_store[$];
    int            m_lens[$];
    int            m_acc;
    int            m_cur;
    logic [2:0]    m_flags;
    logic [PW-1:0] m_pkt;

    ranc_tick_packet_feeder dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .wr_en               (wr_en),
        .wr_packet           (wr_packet),
        .wr_frame_end        (wr_frame_end),
        .full                (full),
        .tick                (tick),
        .ren_to_input_buffer (ren),
        .packet_in           (packet_in),
        .input_buffer_empty  (input_buffer_empty),
        .frames_pending      (frames_pending),
        .error_flags         (error_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return the model to its post-reset contents
    task automatic model_clear();
        m_store.delete();
        m_lens.delete();
        m_acc   = 0;
        m_cur   = 0;
        m_flags = 3'b000;
        m_pkt   = '0;
    endtask

    // Apply one cycle of host/grid activity to the model using the state
    // seen before the clock edge
    task automatic model_step(input logic we, input logic [PW-1:0] pkt,
                              input logic fe, input logic tk, input logic rn);
        bit            store_full;
        bit            lens_full;
        logic [PW-1:0] dummy;
        store_full = (m_store.size() >= DEPTH);
        lens_full  = (m_lens.size() >= FDEPTH);
        if (tk) begin
            if (m_cur > 0) begin
                for (int i = 0; i < m_cur; i++) dummy = m_store.pop_front();
                m_flags[2] = 1'b1;
            end
            m_cur = 0;
            if (m_lens.size() > 0) m_cur = m_lens.pop_front();
            else m_flags[1] = 1'b1;
        end else if (rn && m_cur > 0) begin
            m_pkt = m_store.pop_front();
            m_cur--;
        end
        if (we) begin
            if (store_full || lens_full) m_flags[0] = 1'b1;
            else begin
                m_store.push_back(pkt);
                m_acc++;
            end
        end
        if (fe) begin
            if (lens_full) m_flags[0] = 1'b1;
            else begin
                m_lens.push_back(m_acc);
                m_acc = 0;
            end
        end
    endtask

    // Drive one clock cycle of inputs; outputs are sampled 1ns after the edge
    task automatic drive(input logic we, input logic [PW-1:0] pkt,
                         input logic fe, input logic tk, input logic rn);
        wr_en        = we;
        wr_packet    = pkt;
        wr_frame_end = fe;
        tick         = tk;
        ren          = rn;
        model_step(we, pkt, fe, tk, rn);
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        wr_frame_end = 1'b0;
        tick         = 1'b0;
        ren          = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Outputs right after reset
    task automatic test_reset();
        do_reset();
        n_checks++; if (packet_in !== '0) begin n_fails++; $display("[TB] FAIL reset_packet_in: got %h want 0", packet_in); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_empty: got %b want 1", input_buffer_empty); end
        n_checks++; if (full !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_full: got %b want 0", full); end
        n_checks++; if (frames_pending !== 8'd0) begin n_fails++; $display("[TB] FAIL reset_frames: got %0d want 0", frames_pending); end
        n_checks++; if (error_flags !== 3'b000) begin n_fails++; $display("[TB] FAIL reset_flags: got %b want 000", error_flags); end
    endtask

    // One frame of three packets released on a tick and read out
    task automatic test_single_frame();
        do_reset();
        drive(1, 30'h1, 0, 0, 0);
        drive(1, 30'h2, 0, 0, 0);
        drive(1, 30'h3, 1, 0, 0);
        n_checks++; if (frames_pending !== 8'd1) begin n_fails++; $display("[TB] FAIL single_pending: got %0d want 1", frames_pending); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL single_empty_pre: got %b want 1", input_buffer_empty); end
        drive(0, '0, 0, 1, 0);
        n_checks++; if (input_buffer_empty !== 1'b0) begin n_fails++; $display("[TB] FAIL single_empty_tick: got %b want 0", input_buffer_empty); end
        n_checks++; if (frames_pending !== 8'd0) begin n_fails++; $display("[TB] FAIL single_pending_tick: got %0d want 0", frames_pending); end
        for (int i = 1; i <= 3; i++) begin
            drive(0, '0, 0, 0, 1);
            n_checks++; if (packet_in !== PW'(i)) begin n_fails++; $display("[TB] FAIL single_read%0d: got %h want %h", i, packet_in, i); end
        end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL single_empty_end: got %b want 1", input_buffer_empty); end
        n_checks++; if (error_flags !== 3'b000) begin n_fails++; $display("[TB] FAIL single_flags: got %b want 000", error_flags); end
    endtask

    // A two-packet frame followed by an empty frame, then an underrun
    task automatic test_back_to_back();
        do_reset();
        drive(1, 30'hA1, 0, 0, 0);
        drive(1, 30'hA2, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        n_checks++; if (frames_pending !== 8'd2) begin n_fails++; $display("[TB] FAIL b2b_pending: got %0d want 2", frames_pending); end
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'hA2) begin n_fails++; $display("[TB] FAIL b2b_last: got %h want a2", packet_in); end
        drive(0, '0, 0, 1, 0);
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_empty_frame: got %b want 1", input_buffer_empty); end
        n_checks++; if (error_flags !== 3'b000) begin n_fails++; $display("[TB] FAIL b2b_no_err: got %b want 000", error_flags); end
        drive(0, '0, 0, 1, 0);
        n_checks++; if (error_flags !== 3'b010) begin n_fails++; $display("[TB] FAIL b2b_underrun: got %b want 010", error_flags); end
    endtask

    // Tick arrives before the grid drains: remainder is skipped
    task automatic test_skip();
        do_reset();
        drive(1, 30'hA, 0, 0, 0);
        drive(1, 30'hB, 0, 0, 0);
        drive(1, 30'hC, 0, 0, 0);
        drive(1, 30'hD, 1, 0, 0);
        drive(1, 30'hE, 1, 0, 0);
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'hA) begin n_fails++; $display("[TB] FAIL skip_first: got %h want a", packet_in); end
        drive(0, '0, 0, 1, 0);
        n_checks++; if (error_flags !== 3'b100) begin n_fails++; $display("[TB] FAIL skip_flag: got %b want 100", error_flags); end
        n_checks++; if (input_buffer_empty !== 1'b0) begin n_fails++; $display("[TB] FAIL skip_empty: got %b want 0", input_buffer_empty); end
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'hE) begin n_fails++; $display("[TB] FAIL skip_next: got %h want e", packet_in); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL skip_empty_end: got %b want 1", input_buffer_empty); end
    endtask

    // Fill the packet store, overflow it by one, then drain everything
    task automatic test_overflow();
        int            bad;
        logic [PW-1:0] bad_got;
        int            bad_idx;
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, PW'(i), 0, 0, 0);
        n_checks++; if (full !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_full: got %b want 1", full); end
        n_checks++; if (error_flags !== 3'b000) begin n_fails++; $display("[TB] FAIL ovf_flags_pre: got %b want 000", error_flags); end
        drive(1, 30'h3FFFFFFF, 0, 0, 0);
        n_checks++; if (error_flags !== 3'b001) begin n_fails++; $display("[TB] FAIL ovf_flag: got %b want 001", error_flags); end
        drive(0, '0, 1, 0, 0);
        n_checks++; if (frames_pending !== 8'd1) begin n_fails++; $display("[TB] FAIL ovf_pending: got %0d want 1", frames_pending); end
        drive(0, '0, 0, 1, 0);
        bad = 0;
        bad_got = '0;
        bad_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, '0, 0, 0, 1);
            if (packet_in !== PW'(i)) begin
                if (bad == 0) begin bad_got = packet_in; bad_idx = i; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) begin n_fails++; $display("[TB] FAIL ovf_drain: %0d wrong, first at %0d got %h want %h", bad, bad_idx, bad_got, bad_idx); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_empty: got %b want 1", input_buffer_empty); end
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== PW'(DEPTH - 1)) begin n_fails++; $display("[TB] FAIL ovf_extra_dropped: got %h want %h", packet_in, DEPTH - 1); end
        n_checks++; if (full !== 1'b0) begin n_fails++; $display("[TB] FAIL ovf_full_end: got %b want 0", full); end
    endtask

    // Reads coinciding with a tick, or with nothing to read, do nothing
    task automatic test_priority_idle();
        do_reset();
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== '0) begin n_fails++; $display("[TB] FAIL idle_read_reset: got %h want 0", packet_in); end
        drive(1, 30'h11, 0, 0, 0);
        drive(1, 30'h22, 1, 0, 0);
        drive(0, '0, 0, 1, 1);
        n_checks++; if (packet_in !== '0) begin n_fails++; $display("[TB] FAIL prio_packet: got %h want 0", packet_in); end
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'h11) begin n_fails++; $display("[TB] FAIL prio_first: got %h want 11", packet_in); end
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'h22) begin n_fails++; $display("[TB] FAIL idle_hold: got %h want 22", packet_in); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL idle_empty: got %b want 1", input_buffer_empty); end
    endtask

    // Reset during a stream discards everything
    task automatic test_reset_mid_stream();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, PW'(32'h100 + i), (i == 4), 0, 0);
        drive(1, 30'h200, 1, 0, 0);
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 1);
        n_checks++; if (packet_in !== 30'h100) begin n_fails++; $display("[TB] FAIL mid_first: got %h want 100", packet_in); end
        reset_n = 1'b0;
        drive(0, '0, 0, 0, 0);
        reset_n = 1'b1;
        model_clear();
        n_checks++; if (packet_in !== '0) begin n_fails++; $display("[TB] FAIL mid_packet: got %h want 0", packet_in); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_empty: got %b want 1", input_buffer_empty); end
        n_checks++; if (frames_pending !== 8'd0) begin n_fails++; $display("[TB] FAIL mid_pending: got %0d want 0", frames_pending); end
        n_checks++; if (error_flags !== 3'b000) begin n_fails++; $display("[TB] FAIL mid_flags: got %b want 000", error_flags); end
        drive(0, '0, 0, 1, 0);
        n_checks++; if (error_flags !== 3'b010) begin n_fails++; $display("[TB] FAIL mid_underrun: got %b want 010", error_flags); end
        n_checks++; if (input_buffer_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_empty_tick: got %b want 1", input_buffer_empty); end
    endtask

    // Random host/grid traffic checked cycle by cycle against the model
    task automatic test_random();
        logic          we, fe, tk, rn;
        logic [PW-1:0] pkt;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            we  = ($urandom_range(0, 1) == 1);
            fe  = ($urandom_range(0, 5) == 0);
            tk  = ($urandom_range(0, 11) == 0);
            rn  = ($urandom_range(0, 2) != 0);
            pkt = PW'($urandom);
            drive(we, pkt, fe, tk, rn);
            n_checks++; if (packet_in !== m_pkt) begin n_fails++; $display("[TB] FAIL rand_packet c%0d: got %h want %h", c, packet_in, m_pkt); end
            n_checks++; if (input_buffer_empty !== (m_cur == 0)) begin n_fails++; $display("[TB] FAIL rand_empty c%0d: got %b want %b", c, input_buffer_empty, (m_cur == 0)); end
            n_checks++; if (frames_pending !== 8'(m_lens.size())) begin n_fails++; $display("[TB] FAIL rand_pending c%0d: got %0d want %0d", c, frames_pending, m_lens.size()); end
            n_checks++; if (error_flags !== m_flags) begin n_fails++; $display("[TB] FAIL rand_flags c%0d: got %b want %b", c, error_flags, m_flags); end
            n_checks++; if (full !== ((m_store.size() == DEPTH) || (m_lens.size() == FDEPTH))) begin n_fails++; $display("[TB] FAIL rand_full c%0d: got %b", c, full); end
        end
    endtask

    // Scenario sequence
    initial begin
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_packet    = '0;
        wr_frame_end = 1'b0;
        tick         = 1'b0;
        ren          = 1'b0;
        model_clear();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_skip();
        test_priority_idle();
        test_reset_mid_stream();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ranc_tick_packet_feeder.md
Name: ranc_tick_packet_feeder

Overview:
- Hardware replacement for the host-side input buffer of the RANC network grid.
- A host writes 30-bit input packets grouped into per-tick frames.
- On each tick the block releases exactly one frame to the grid. The grid reads it through the ren_to_input_buffer / input_buffer_empty / packet_in handshake.
- Sits between the host loader (DMA/UART) and the grid's input port.

Parameters:
- PACKET_WIDTH, 30, width of one grid input packet.
- DEPTH, 16384, packet storage entries (power of two).
- FRAME_DEPTH, 128, queued frame-length entries (power of two).
- COUNT_WIDTH, 15, width of per-frame packet count; must satisfy 2^COUNT_WIDTH > DEPTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  host pushes wr_packet this cycle.
- wr_packet  in  PACKET_WIDTH  packet data.
- wr_frame_end  in  1  closes the current frame after any same-cycle push; legal with wr_en=0 (closes an empty frame or the packets already pushed).
- full  out  1  packet store full or frame queue full; host must not write while high.
- tick  in  1  one-cycle tick pulse, shared with the grid.
- ren_to_input_buffer  in  1  grid read request.
- packet_in  out  PACKET_WIDTH  packet to grid, registered.
- input_buffer_empty  out  1  no packet left to release in the current tick.
- frames_pending  out  $clog2(FRAME_DEPTH)+1  number of closed frames queued, not yet released.
- error_flags  out  3  sticky errors: [0] write overflow, [1] tick underrun, [2] frame skipped.

Behaviour:
- Reset values: packet_in=0, input_buffer_empty=1, full=0, frames_pending=0, error_flags=0. Both internal FIFOs are emptied and the frame accumulator is cleared.
- Reset mid-operation discards all stored packets and frames with no further output.

Write side:
- wr_en && !full: store the packet and increment the accumulator acc_cnt.
- wr_frame_end: push acc_cnt + (accepted same-cycle wr_en ? 1 : 0) to the frame queue, then set acc_cnt = 0.
- A write while full is dropped and sets error_flags[0].
- wr_frame_end while the frame queue is full is dropped, sets error_flags[0], and acc_cnt is kept.

Release FSM, states WAIT_TICK and STREAM:
- WAIT_TICK:
  - On tick with frames_pending>0: pop frame length L into remaining. If L>0 go to STREAM, else stay.
  - On tick with frames_pending==0: set error_flags[1], stay. The grid sees no packets this tick.
- STREAM:
  - ren_to_input_buffer && remaining>0: on the next rising edge, packet_in takes the next stored packet and remaining decrements. Latency from ren to packet_in valid is 1 cycle.
  - When remaining reaches 0, go to WAIT_TICK.
- tick arriving in STREAM with remaining>0 (grid did not drain):
  - Advance the read pointer by remaining, discarding those packets, and set error_flags[2].
  - Then load the next frame exactly as in WAIT_TICK, in the same cycle.
- input_buffer_empty = (remaining==0), registered.
  - Deasserts the cycle after a tick that loads L>0.
  - Asserts the cycle after the last read.
- tick has priority over ren in the same cycle: that ren is ignored.
- ren while empty is ignored and packet_in holds its value.
- packet_in holds its last value between reads.
- Simultaneous host write and grid read are independent.
- Write pointers and read pointers wrap modulo DEPTH and FRAME_DEPTH.
- A frame is never released until its wr_frame_end has been accepted.

Decomposition:
- Shared package ranc_pkg holds:
  - PACKET_WIDTH
  - grid packet field widths and offsets (dx, dy, axon, tick offset)
  - the error_flags bit index constants
- One natural sub-module, ranc_sync_fifo (parameterised width/depth, count output, flush-by-N input). It is instantiated twice: packet store (width PACKET_WIDTH) and frame queue (width COUNT_WIDTH).
- FSM, accumulator and error logic stay in the top module.

Test Plan:
- Single frame: write 3 packets (0x1,0x2,0x3) with wr_frame_end on the 3rd, then tick.
  - Required: input_buffer_empty falls 1 cycle after tick.
  - Three ren cycles yield packet_in 0x1,0x2,0x3 each 1 cycle after its ren.
  - Empty rises after the 3rd; frames_pending 1→0.
- Back-to-back frames: queue frames of 2 and 0 packets, then tick, drain, tick.
  - Required: second tick leaves empty=1 with no error.
  - A third tick sets error_flags[1].
- Skip: queue frames of 4 (A..D) and 1 (E); tick; read 1 (A); tick.
  - Required: error_flags[2] set, and the next ren returns E, not B.
- Overflow: fill DEPTH packets, then write one more.
  - Required: full=1, the extra packet is dropped, error_flags[0]=1.
  - After a frame close, drain returns exactly DEPTH packets.
- Priority and idle reads: ren asserted on the same cycle as tick, and ren while empty.
  - Required: no packet consumed, remaining unchanged, packet_in stable.
- Reset mid-STREAM after 1 of 5 reads.
  - Required: the cycle after reset, all outputs are at reset values and frames_pending=0.
  - A subsequent tick sets error_flags[1] only.
